// File: rtl/hazard_scheduler.sv
// hazard_scheduler: pipeline hazard controller for the 5-stage RV32I core.
// Produces the registered EX-from-MEM forwarding select (hazard_op), stage
// stall/flush controls for memory waits, taken branches and traps, and a
// watchdog pulse for data-memory accesses that stay unacknowledged too long.
//
// Ports
//   clk, reset                 core clock (rising edge), async active-high reset
//   ID_rs1, ID_rs2             source registers of the instruction in ID
//   ID_uses_rs1, ID_uses_rs2   ID instruction reads rs1 / rs2
//   EX_rd, EX_reg_write        destination of the instruction in EX, and its write enable
//   dmem_req, dmem_ready       MEM-stage access active / accepted this cycle
//   branch_taken, trap         EX redirect / trap taken this cycle
//   hazard_op[1:0]             registered: [0] fwd rs1 from MEM, [1] fwd rs2 from MEM
//   *_stall                    hold the PC / IF_ID / ID_EX / EX_MEM registers
//   *_flush                    insert a bubble into IF_ID / ID_EX / EX_MEM / MEM_WB
//   dmem_timeout               one-cycle pulse when a memory wait reaches the watchdog limit
//   sched_state[1:0]           00 RUN, 01 MEM_WAIT, 10 FLUSH
module hazard_scheduler #(
   parameter int unsigned REG_ADDR_W   = 5,
   parameter int unsigned WAIT_TIMEOUT = 16,
   parameter int unsigned WAIT_CNT_W   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] ID_rs1,
   input  logic [REG_ADDR_W-1:0] ID_rs2,
   input  logic                  ID_uses_rs1,
   input  logic                  ID_uses_rs2,
   input  logic [REG_ADDR_W-1:0] EX_rd,
   input  logic                  EX_reg_write,
   input  logic                  dmem_req,
   input  logic                  dmem_ready,
   input  logic                  branch_taken,
   input  logic                  trap,
   output logic [1:0]            hazard_op,
   output logic                  pc_stall,
   output logic                  IF_ID_stall,
   output logic                  ID_EX_stall,
   output logic                  EX_MEM_stall,
   output logic                  IF_ID_flush,
   output logic                  ID_EX_flush,
   output logic                  EX_MEM_flush,
   output logic                  MEM_WB_flush,
   output logic                  dmem_timeout,
   output logic [1:0]            sched_state
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      FLUSH    = 2'b10
   } state_t;

   localparam logic [WAIT_CNT_W-1:0] CNT_MAX = WAIT_CNT_W'(WAIT_TIMEOUT - 1);

   state_t                state;
   state_t                state_nxt;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  timeout_done;
   logic                  mem_stall;
   logic                  fwd_rs1;
   logic                  fwd_rs2;

   // A trap always wins over a pending memory access.
   assign mem_stall   = dmem_req & ~dmem_ready & ~trap;
   assign sched_state = state;

   // Forwarding relation between the ID sources and the EX destination; x0 never forwards.
   assign fwd_rs1 = ID_uses_rs1 & EX_reg_write & (EX_rd != '0) & (EX_rd == ID_rs1);
   assign fwd_rs2 = ID_uses_rs2 & EX_reg_write & (EX_rd != '0) & (EX_rd == ID_rs2);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   // Next state and stage controls. Priority: trap > memory stall > branch / FLUSH bubble.
   // Controls are forced low while reset is held so every output is 0 during reset.
   always_comb begin
      state_nxt    = state;
      pc_stall     = 1'b0;
      IF_ID_stall  = 1'b0;
      ID_EX_stall  = 1'b0;
      EX_MEM_stall = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_MEM_flush = 1'b0;
      MEM_WB_flush = 1'b0;
      dmem_timeout = 1'b0;
      if (!reset) begin
         if (trap) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            MEM_WB_flush = 1'b1;
            state_nxt    = FLUSH;
         end else if (mem_stall) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_flush = 1'b1;
            dmem_timeout = (wait_cnt == CNT_MAX) & ~timeout_done;
            state_nxt    = MEM_WAIT;
         end else begin
            case (state)
               FLUSH:   IF_ID_flush = 1'b1;
               default: IF_ID_flush = 1'b0;
            endcase
            if (branch_taken) begin
               IF_ID_flush = 1'b1;
               ID_EX_flush = 1'b1;
            end
            state_nxt = RUN;
         end
      end
   end

   // Wait counter: holds (stalled cycles so far - 1) during a wait, saturating;
   // cleared by any non-stalled cycle so each wait starts from 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt     <= '0;
         timeout_done <= 1'b0;
      end else if (mem_stall) begin
         if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
         if (dmem_timeout)        timeout_done <= 1'b1;
      end else begin
         wait_cnt     <= '0;
         timeout_done <= 1'b0;
      end
   end

   // Forwarding select: frozen with EX/MEM during a stall, cleared behind any ID/EX bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hazard_op <= 2'b00;
      end else if (!mem_stall) begin
         if (ID_EX_flush || state == FLUSH) hazard_op <= 2'b00;
         else                               hazard_op <= {fwd_rs2, fwd_rs1};
      end
   end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed + randomized stimulus for hazard_scheduler.
// A stimulus process drives each cycle and pushes the expected outputs from a
// cycle-level behavioural model; a monitor pops and compares on the falling edge.
module tb_hazard_scheduler;

   localparam int unsigned WT = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
   logic       ID_uses_rs1 = 1'b0, ID_uses_rs2 = 1'b0, EX_reg_write = 1'b0;
   logic       dmem_req = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0, trap = 1'b0;
   logic [1:0] hazard_op, sched_state;
   logic       pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
   logic       IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, dmem_timeout;

   hazard_scheduler #(.REG_ADDR_W(5), .WAIT_TIMEOUT(WT), .WAIT_CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
      .EX_rd(EX_rd), .EX_reg_write(EX_reg_write),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .branch_taken(branch_taken), .trap(trap),
      .hazard_op(hazard_op),
      .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
      .EX_MEM_stall(EX_MEM_stall),
      .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
      .MEM_WB_flush(MEM_WB_flush), .dmem_timeout(dmem_timeout), .sched_state(sched_state)
   );

   always #5 clk = ~clk;

   // Expected word: {hazard_op, pc/IF_ID/ID_EX/EX_MEM stall, IF_ID/ID_EX/EX_MEM/MEM_WB flush, timeout, state}
   logic [12:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   // Model state: forwarding select, mode (0 run, 1 waiting, 2 post-trap bubble),
   // and the number of stalled cycles seen in the current memory wait.
   logic [1:0]  m_hop   = 2'b00;
   int          m_mode  = 0;
   int          m_stalls = 0;

   function automatic logic fwd(input logic uses, input logic wr, input logic [4:0] rd,
                                input logic [4:0] rs);
      return uses && wr && (rd != 5'd0) && (rd == rs);
   endfunction

   task automatic step(input logic rst_i, input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                       input logic u1_i, input logic u2_i, input logic [4:0] rd_i,
                       input logic rw_i, input logic req_i, input logic rdy_i,
                       input logic br_i, input logic tr_i);
      logic [3:0]  st;
      logic [3:0]  fl;
      logic        to;
      logic        stall;
      int          n;
      @(posedge clk);
      #2;
      reset = rst_i; ID_rs1 = rs1_i; ID_rs2 = rs2_i; ID_uses_rs1 = u1_i; ID_uses_rs2 = u2_i;
      EX_rd = rd_i; EX_reg_write = rw_i; dmem_req = req_i; dmem_ready = rdy_i;
      branch_taken = br_i; trap = tr_i;
      if (rst_i) begin
         m_hop = 2'b00; m_mode = 0; m_stalls = 0;
         exp_q.push_back(13'd0);
      end else begin
         stall = req_i && !rdy_i && !tr_i;
         n     = stall ? m_stalls + 1 : 0;
         st = 4'b0000; fl = 4'b0000; to = 1'b0;
         if (tr_i) begin
            fl = 4'b1111;
         end else if (stall) begin
            st = 4'b1111; fl = 4'b0001;
            to = (n == int'(WT));
         end else begin
            fl = {br_i || (m_mode == 2), br_i, 2'b00};
         end
         exp_q.push_back({m_hop, st, fl, to, 2'(m_mode)});
         if (!stall) begin
            if (tr_i || br_i || m_mode == 2) m_hop = 2'b00;
            else m_hop = {fwd(u2_i, rw_i, rd_i, rs2_i), fwd(u1_i, rw_i, rd_i, rs1_i)};
         end
         m_mode   = tr_i ? 2 : (stall ? 1 : 0);
         m_stalls = n;
      end
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: outputs are presented every cycle; compare away from the rising edge.
   initial begin
      logic [12:0] e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {hazard_op, pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
                 IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, dmem_timeout, sched_state};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL cycle%0d outputs got=%b want=%b (hop|stalls|flushes|to|state)",
                        cyc, a, e);
            end
            cyc++;
         end
      end
   end

   initial begin
      // Reset value, then forwarding patterns.
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      // Taken branch with a live match.
      step(1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle();
      // Memory wait holding hazard_op = 10, released by ready.
      step(1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle();
      // Watchdog: ready never comes, then a trap ends the wait.
      repeat (6) step(1'b0, 5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle();
      idle();
      // Trap arriving in FLUSH, then reset mid-wait.
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle();
      repeat (5) step(1'b0, 5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 5'd1, 5'd1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      // Randomized traffic over a small register set so matches are frequent.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 199) == 0,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3,
              $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0);
      end
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
